// File: rtl/bpf_pkt_responder_pkg.sv
// Shared definitions for the BPF packet-buffer responder.
// Contents: FSM state encodings, transfer_sz encodings (BPF_W/H/B), and
// helper functions for access size and big-endian byte-lane selection.
package bpf_pkt_responder_pkg;

    typedef enum logic [1:0] {
        ST_FILL  = 2'b00,
        ST_READY = 2'b01,
        ST_FWD   = 2'b10
    } state_t;

    localparam logic [1:0] BPF_W   = 2'b00;
    localparam logic [1:0] BPF_H   = 2'b01;
    localparam logic [1:0] BPF_B   = 2'b10;
    localparam logic [1:0] BPF_RSV = 2'b11;

    // Number of bytes touched by an access of the given size (0 for reserved).
    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        logic [2:0] n;
        case (sz)
            BPF_W:   n = 3'd4;
            BPF_H:   n = 3'd2;
            BPF_B:   n = 3'd1;
            default: n = 3'd0;
        endcase
        return n;
    endfunction

    // Pick the access starting at byte lane 'lane' of the 64-bit big-endian
    // concatenation {word, next_word}; result is zero-extended, right-aligned.
    function automatic logic [31:0] lane_select(input logic [63:0] cat,
                                                input logic [1:0]  lane,
                                                input logic [1:0]  sz);
        logic [63:0] shifted;
        logic [31:0] res;
        shifted = cat << {lane, 3'b000};
        case (sz)
            BPF_W:   res = shifted[63:32];
            BPF_H:   res = {16'h0000, shifted[63:48]};
            BPF_B:   res = {24'h000000, shifted[63:56]};
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/pkt_wordram.sv
// Packet word RAM: one synchronous write port, three asynchronous read ports
// (two for the CPU's unaligned reads, one for egress). Contents are not reset.
// Ports:
//   i_clk                 clock
//   i_we/i_waddr/i_wdata  write port
//   i_raddr_a/o_rdata_a   CPU read, first word
//   i_raddr_b/o_rdata_b   CPU read, following word
//   i_raddr_c/o_rdata_c   egress read
module pkt_wordram #(
    parameter int WA = 8
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [WA-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic [WA-1:0] i_raddr_a,
    output logic [31:0]   o_rdata_a,
    input  logic [WA-1:0] i_raddr_b,
    output logic [31:0]   o_rdata_b,
    input  logic [WA-1:0] i_raddr_c,
    output logic [31:0]   o_rdata_c
);

    logic [31:0] r_mem [0:(2**WA)-1];

    // Write port
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];
    assign o_rdata_c = r_mem[i_raddr_c];

endmodule

// File: rtl/bpf_pkt_responder.sv
// Packet-buffer responder for the BPF VM CPU.
// Loads one packet from the ingress word stream (FILL), lets the CPU run its
// filter with 1-cycle big-endian reads (READY), then streams the packet out on
// accept (FWD) or drops it on reject.
// Ports:
//   clk, rst (sync, active-high)
//   in_*        ingress word stream (in_bytes: valid bytes of last word, 0 = 4)
//   mem_ready   packet loaded, CPU may run
//   rd_*        CPU packet reads; rd_data/rd_err valid one cycle after rd_en
//   pkt_len     packet length in bytes, trunc = packet exceeded capacity
//   accept/reject  CPU verdict
//   out_*       egress word stream
module bpf_pkt_responder
    import bpf_pkt_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [31:0]           in_data,
    input  logic                  in_last,
    input  logic [1:0]            in_bytes,
    output logic                  in_ready,
    output logic                  mem_ready,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [1:0]            transfer_sz,
    output logic [31:0]           rd_data,
    output logic                  rd_err,
    output logic [ADDR_WIDTH:0]   pkt_len,
    output logic                  trunc,
    input  logic                  accept,
    input  logic                  reject,
    output logic                  out_valid,
    output logic [31:0]           out_data,
    output logic                  out_last,
    output logic [1:0]            out_bytes,
    input  logic                  out_ready
);

    localparam int WA = ADDR_WIDTH - 2;
    localparam logic [ADDR_WIDTH:0] LEN_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                r_state;
    state_t                w_next;
    // One extra bit: r_wr_ptr[WA] set means the RAM is full.
    logic [WA:0]           r_wr_ptr;
    logic [WA-1:0]         r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_pkt_len;
    logic                  r_trunc;
    logic [31:0]           r_rd_data;
    logic                  r_rd_err;

    logic                  w_in_hs;
    logic                  w_wr_full;
    logic                  w_ram_we;
    logic [ADDR_WIDTH:0]   w_tail;
    logic [ADDR_WIDTH:0]   w_last_len;
    logic                  w_reject;
    logic                  w_accept;
    logic [ADDR_WIDTH:0]   w_last_idx;
    logic                  w_out_last;
    logic                  w_out_hs;
    logic [WA-1:0]         w_rd_word0;
    logic [WA-1:0]         w_rd_word1;
    logic [31:0]           w_rdata0;
    logic [31:0]           w_rdata1;
    logic [ADDR_WIDTH:0]   w_rd_end;
    logic                  w_rd_bad;

    assign w_in_hs    = in_valid && (r_state == ST_FILL);
    assign w_wr_full  = r_wr_ptr[WA];
    assign w_ram_we   = w_in_hs && !w_wr_full;
    assign w_tail     = (in_bytes == 2'b00) ? {(ADDR_WIDTH+1){1'b0}}
                                            : (ADDR_WIDTH+1)'(3'd4 - {1'b0, in_bytes});
    // Length if the current word is the (stored) last word.
    assign w_last_len = {r_wr_ptr, 2'b00} + (ADDR_WIDTH+1)'(4) - w_tail;

    assign w_reject   = (r_state == ST_READY) && reject;
    assign w_accept   = (r_state == ST_READY) && accept && !reject;

    // Index of final egress word: ceil(pkt_len/4) - 1.
    assign w_last_idx = ((r_pkt_len + (ADDR_WIDTH+1)'(3)) >> 2) - (ADDR_WIDTH+1)'(1);
    assign w_out_last = (r_state == ST_FWD) &&
                        ({{(ADDR_WIDTH+1-WA){1'b0}}, r_rd_ptr} == w_last_idx);
    assign w_out_hs   = (r_state == ST_FWD) && out_ready;

    assign w_rd_word0 = rd_addr[ADDR_WIDTH-1:2];
    assign w_rd_word1 = w_rd_word0 + WA'(1);
    assign w_rd_end   = {1'b0, rd_addr} + (ADDR_WIDTH+1)'(size_bytes(transfer_sz));
    assign w_rd_bad   = (transfer_sz == BPF_RSV) || (w_rd_end > r_pkt_len);

    pkt_wordram #(.WA(WA)) u_ram (
        .i_clk     (clk),
        .i_we      (w_ram_we),
        .i_waddr   (r_wr_ptr[WA-1:0]),
        .i_wdata   (in_data),
        .i_raddr_a (w_rd_word0),
        .o_rdata_a (w_rdata0),
        .i_raddr_b (w_rd_word1),
        .o_rdata_b (w_rdata1),
        .i_raddr_c (r_rd_ptr),
        .o_rdata_c (out_data)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_FILL: begin
                if (w_in_hs && in_last) w_next = ST_READY;
                else                    w_next = ST_FILL;
            end
            ST_READY: begin
                if (w_reject)      w_next = ST_FILL;
                else if (w_accept) w_next = ST_FWD;
                else               w_next = ST_READY;
            end
            ST_FWD: begin
                if (w_out_hs && w_out_last) w_next = ST_FILL;
                else                        w_next = ST_FWD;
            end
            default: w_next = ST_FILL;
        endcase
    end

    // Pointers, length and truncation flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_pkt_len <= '0;
            r_trunc   <= 1'b0;
        end else begin
            case (r_state)
                ST_FILL: begin
                    if (w_in_hs) begin
                        if (w_wr_full) r_trunc  <= 1'b1;
                        else           r_wr_ptr <= r_wr_ptr + (WA+1)'(1);
                        // A discarded last word leaves the length saturated.
                        if (in_last) r_pkt_len <= w_wr_full ? LEN_MAX : w_last_len;
                    end
                end
                ST_READY: begin
                    if (w_reject) begin
                        r_wr_ptr  <= '0;
                        r_pkt_len <= '0;
                        r_trunc   <= 1'b0;
                    end
                end
                ST_FWD: begin
                    if (w_out_hs) begin
                        if (w_out_last) begin
                            r_wr_ptr  <= '0;
                            r_rd_ptr  <= '0;
                            r_pkt_len <= '0;
                            r_trunc   <= 1'b0;
                        end else begin
                            r_rd_ptr <= r_rd_ptr + WA'(1);
                        end
                    end
                end
                default: begin
                    r_rd_ptr <= '0;
                end
            endcase
        end
    end

    // CPU read result register; holds between accepted reads
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= 32'h0000_0000;
            r_rd_err  <= 1'b0;
        end else if (rd_en && (r_state == ST_READY)) begin
            r_rd_err  <= w_rd_bad;
            r_rd_data <= w_rd_bad ? 32'h0000_0000
                                  : lane_select({w_rdata0, w_rdata1}, rd_addr[1:0], transfer_sz);
        end
    end

    assign in_ready  = (r_state == ST_FILL);
    assign mem_ready = (r_state == ST_READY);
    assign out_valid = (r_state == ST_FWD);
    assign out_last  = w_out_last;
    assign out_bytes = w_out_last ? r_pkt_len[1:0] : 2'b00;
    assign rd_data   = r_rd_data;
    assign rd_err    = r_rd_err;
    assign pkt_len   = r_pkt_len;
    assign trunc     = r_trunc;

endmodule

// File: tb/tb_bpf_pkt_responder.sv
// Scoreboard bench for bpf_pkt_responder: stimulus pushes expected read and
// egress results into queues; monitors pop and compare on DUT outputs.
module tb_bpf_pkt_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_last, in_ready, mem_ready;
    logic [31:0] in_data;
    logic [1:0]  in_bytes;
    logic        rd_en;
    logic [9:0]  rd_addr;
    logic [1:0]  transfer_sz;
    logic [31:0] rd_data;
    logic        rd_err;
    logic [10:0] pkt_len;
    logic        trunc, accept, reject;
    logic        out_valid, out_last, out_ready;
    logic [31:0] out_data;
    logic [1:0]  out_bytes;

    // Small instance (ADDR_WIDTH=4) for capacity overflow
    logic        s_in_valid, s_in_last, s_in_ready, s_mem_ready;
    logic [31:0] s_in_data;
    logic [1:0]  s_in_bytes;
    logic [31:0] s_rd_data;
    logic        s_rd_err;
    logic [4:0]  s_pkt_len;
    logic        s_trunc, s_out_valid, s_out_last;
    logic [31:0] s_out_data;
    logic [1:0]  s_out_bytes;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] d;
        logic        l;
        logic [1:0]  b;
    } eg_t;

    logic [32:0] rd_q[$];
    eg_t         eg_q[$];
    logic        rd_check = 1'b0;
    logic [31:0] last_d = 32'h0;
    logic        last_e = 1'b0;

    always #5 clk = ~clk;

    bpf_pkt_responder #(.ADDR_WIDTH(10)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_bytes(in_bytes), .in_ready(in_ready), .mem_ready(mem_ready),
        .rd_en(rd_en), .rd_addr(rd_addr), .transfer_sz(transfer_sz),
        .rd_data(rd_data), .rd_err(rd_err), .pkt_len(pkt_len), .trunc(trunc),
        .accept(accept), .reject(reject),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_bytes(out_bytes), .out_ready(out_ready)
    );

    bpf_pkt_responder #(.ADDR_WIDTH(4)) dut_s (
        .clk(clk), .rst(rst),
        .in_valid(s_in_valid), .in_data(s_in_data), .in_last(s_in_last),
        .in_bytes(s_in_bytes), .in_ready(s_in_ready), .mem_ready(s_mem_ready),
        .rd_en(1'b0), .rd_addr(4'h0), .transfer_sz(2'b00),
        .rd_data(s_rd_data), .rd_err(s_rd_err), .pkt_len(s_pkt_len), .trunc(s_trunc),
        .accept(1'b0), .reject(1'b0),
        .out_valid(s_out_valid), .out_data(s_out_data), .out_last(s_out_last),
        .out_bytes(s_out_bytes), .out_ready(1'b1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic l, input logic [1:0] b);
        in_valid = 1'b1; in_data = d; in_last = l; in_bytes = b;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic rd(input logic [9:0] a, input logic [1:0] sz, input logic served,
                      input logic [31:0] ed, input logic ee);
        if (served) begin
            last_d = ed;
            last_e = ee;
        end
        rd_q.push_back({last_e, last_d});
        rd_en = 1'b1; rd_addr = a; transfer_sz = sz;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic load3;
        send(32'h11223344, 1'b0, 2'd0);
        send(32'h55667788, 1'b0, 2'd0);
        send(32'hAABB0000, 1'b1, 2'd2);
    endtask

    // Read-result monitor: one result per cycle after rd_en
    always @(posedge clk) rd_check <= rd_en;

    always @(negedge clk) begin
        if (rd_check) begin
            total++;
            if (rd_q.size() == 0) begin
                bad++;
                $display("FAIL rd_unexpected: got data 0x%08h err %0b with no expectation", rd_data, rd_err);
            end else begin
                logic [32:0] e;
                e = rd_q.pop_front();
                if ({rd_err, rd_data} !== e) begin
                    bad++;
                    $display("FAIL rd_result: got err %0b data 0x%08h expected err %0b data 0x%08h",
                             rd_err, rd_data, e[32], e[31:0]);
                end
            end
        end
    end

    // Egress monitor: compare each handshaken word
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            total++;
            if (eg_q.size() == 0) begin
                bad++;
                $display("FAIL eg_unexpected: got 0x%08h last %0b", out_data, out_last);
            end else begin
                eg_t e;
                e = eg_q.pop_front();
                if ({out_data, out_last, out_bytes} !== e) begin
                    bad++;
                    $display("FAIL eg_word: got 0x%08h last %0b bytes %0d expected 0x%08h last %0b bytes %0d",
                             out_data, out_last, out_bytes, e.d, e.l, e.b);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got hang expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] ordy [4];
        ordy[0] = 1'b1; ordy[1] = 1'b0; ordy[2] = 1'b1; ordy[3] = 1'b1;
        rst = 1'b1; in_valid = 1'b0; in_data = 32'h0; in_last = 1'b0; in_bytes = 2'd0;
        rd_en = 1'b0; rd_addr = 10'h0; transfer_sz = 2'b00;
        accept = 1'b0; reject = 1'b0; out_ready = 1'b0;
        s_in_valid = 1'b0; s_in_data = 32'h0; s_in_last = 1'b0; s_in_bytes = 2'd0;
        tick(); tick();
        rst = 1'b0;

        // Reset values
        check("rst_in_ready",  {31'h0, in_ready},  32'h1);
        check("rst_mem_ready", {31'h0, mem_ready}, 32'h0);
        check("rst_rd_data",   rd_data,            32'h0);
        check("rst_rd_err",    {31'h0, rd_err},    32'h0);
        check("rst_pkt_len",   {21'h0, pkt_len},   32'h0);
        check("rst_trunc",     {31'h0, trunc},     32'h0);
        check("rst_out",       {28'h0, out_valid, out_last, out_bytes}, 32'h0);

        // Load 10-byte packet
        send(32'h11223344, 1'b0, 2'd0);
        send(32'h55667788, 1'b0, 2'd0);
        check("fill_mem_ready_low", {31'h0, mem_ready}, 32'h0);
        send(32'hAABB0000, 1'b1, 2'd2);
        check("load_pkt_len",   {21'h0, pkt_len},   32'd10);
        check("load_mem_ready", {31'h0, mem_ready}, 32'h1);
        check("load_in_ready",  {31'h0, in_ready},  32'h0);

        // CPU reads
        rd(10'd1, 2'b10, 1'b1, 32'h00000022, 1'b0);
        rd(10'd3, 2'b01, 1'b1, 32'h00004455, 1'b0);
        rd(10'd6, 2'b00, 1'b1, 32'h7788AABB, 1'b0);
        rd(10'd8, 2'b00, 1'b1, 32'h00000000, 1'b1);
        rd(10'd8, 2'b01, 1'b1, 32'h0000AABB, 1'b0);
        rd(10'd0, 2'b11, 1'b1, 32'h00000000, 1'b1);
        rd(10'd9, 2'b10, 1'b1, 32'h000000BB, 1'b0);
        rd(10'd10, 2'b10, 1'b1, 32'h00000000, 1'b1);
        tick();
        check("rd_hold_err", {31'h0, rd_err}, 32'h1);

        // Accept and stream with out_ready 1,0,1,1
        eg_q.push_back('{32'h11223344, 1'b0, 2'd0});
        eg_q.push_back('{32'h55667788, 1'b0, 2'd0});
        eg_q.push_back('{32'hAABB0000, 1'b1, 2'd2});
        accept = 1'b1; out_ready = 1'b1;
        tick();
        accept = 1'b0;
        check("acc_out_valid", {31'h0, out_valid}, 32'h1);
        check("acc_mem_ready", {31'h0, mem_ready}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            out_ready = ordy[i][0];
            tick();
        end
        out_ready = 1'b0;
        check("fwd_done_in_ready",  {31'h0, in_ready},  32'h1);
        check("fwd_done_out_valid", {31'h0, out_valid}, 32'h0);
        check("fwd_done_pkt_len",   {21'h0, pkt_len},   32'h0);
        check("fwd_eg_q_empty",     eg_q.size(),        32'h0);

        // Read while in FILL is ignored; held value returned
        rd(10'd0, 2'b10, 1'b0, 32'h0, 1'b0);

        // Reject wins over accept
        send(32'hCAFEF00D, 1'b0, 2'd0);
        send(32'h01020304, 1'b1, 2'd0);
        check("rej_pkt_len_before", {21'h0, pkt_len}, 32'd8);
        accept = 1'b1; reject = 1'b1;
        tick();
        accept = 1'b0; reject = 1'b0;
        check("rej_out_valid", {31'h0, out_valid}, 32'h0);
        check("rej_in_ready",  {31'h0, in_ready},  32'h1);
        check("rej_pkt_len",   {21'h0, pkt_len},   32'h0);

        // Overflow on the small instance: exactly full, then one beyond
        for (int i = 0; i < 5; i++) begin
            s_in_valid = 1'b1; s_in_data = 32'h1000 + i; s_in_last = (i == 4); s_in_bytes = 2'd1;
            tick();
            if (i == 3) check("ovf_full_no_trunc", {31'h0, s_trunc}, 32'h0);
        end
        s_in_valid = 1'b0; s_in_last = 1'b0;
        check("ovf_trunc",     {31'h0, s_trunc},     32'h1);
        check("ovf_pkt_len",   {27'h0, s_pkt_len},   32'd16);
        check("ovf_mem_ready", {31'h0, s_mem_ready}, 32'h1);

        // Reset mid-FWD after one word
        load3();
        eg_q.push_back('{32'h11223344, 1'b0, 2'd0});
        accept = 1'b1; out_ready = 1'b0;
        tick();
        accept = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        last_d = 32'h0; last_e = 1'b0;
        check("rstfwd_out_valid", {31'h0, out_valid}, 32'h0);
        check("rstfwd_out_last",  {31'h0, out_last},  32'h0);
        check("rstfwd_in_ready",  {31'h0, in_ready},  32'h1);

        // One-byte packet
        send(32'hDEADBEEF, 1'b1, 2'd1);
        check("one_pkt_len", {21'h0, pkt_len}, 32'd1);
        rd(10'd0, 2'b10, 1'b1, 32'h000000DE, 1'b0);
        rd(10'd1, 2'b10, 1'b1, 32'h00000000, 1'b1);
        rd(10'd0, 2'b01, 1'b1, 32'h00000000, 1'b1);
        reject = 1'b1;
        tick();
        reject = 1'b0;

        // Drain scoreboards with a bounded wait
        for (int i = 0; i < 20 && (rd_q.size() != 0 || eg_q.size() != 0); i++) tick();
        check("final_rd_q_empty", rd_q.size(), 32'h0);
        check("final_eg_q_empty", eg_q.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
